// File: rtl/coin_start_sequencer.sv
// Turns start-1P / start-2P / coin-only requests into timed coin and start pulse trains
// for the core. One start press inserts the credits that game needs before the start pulse.
module coin_start_sequencer #(
  parameter int PULSE_CYC    = 400000,
  parameter int GAP_CYC      = 400000,
  parameter int COOLDOWN_CYC = 800000
) (
  input  logic CLK_IN,
  input  logic I_RESET,
  input  logic I_START1,
  input  logic I_START2,
  input  logic I_COIN,
  output logic O_COIN,
  output logic O_START1,
  output logic O_START2,
  output logic O_BUSY
);

  localparam int MAX_PG = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAX_P  = (MAX_PG > COOLDOWN_CYC) ? MAX_PG : COOLDOWN_CYC;
  localparam int CNT_W  = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, COIN, GAP, START, COOL} state_t;
  typedef enum logic [1:0] {JOB_START1, JOB_START2, JOB_COIN} job_t;

  state_t           state_q, state_d;
  job_t             job_q, job_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       coins_left_q, coins_left_d;
  // Bit order for request vectors: [0]=start1, [1]=start2, [2]=coin
  logic [2:0]       in_q, in_d;
  logic [2:0]       pend_q, pend_d;
  logic             coin_q, coin_d;
  logic             start1_q, start1_d;
  logic             start2_q, start2_d;
  logic             busy_q, busy_d;
  logic [2:0]       edge_now;

  always_comb begin
    in_d         = {I_COIN, I_START2, I_START1};
    edge_now     = in_d & ~in_q;
    state_d      = state_q;
    job_d        = job_q;
    cnt_d        = cnt_q;
    coins_left_d = coins_left_q;
    pend_d       = pend_q;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = COIN;
          cnt_d   = PULSE_LD;
          if (pend_q[0]) begin
            job_d        = JOB_START1;
            coins_left_d = 2'd1;
            pend_d[0]    = 1'b0;
          end else if (pend_q[1]) begin
            job_d        = JOB_START2;
            coins_left_d = 2'd2;
            pend_d[1]    = 1'b0;
          end else begin
            job_d        = JOB_COIN;
            coins_left_d = 2'd1;
            pend_d[2]    = 1'b0;
          end
        end
      end
      COIN: begin
        if (cnt_q == '0) begin
          state_d      = GAP;
          cnt_d        = GAP_LD;
          coins_left_d = coins_left_q - 2'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (coins_left_q != 2'd0) begin
            state_d = COIN;
            cnt_d   = PULSE_LD;
          end else if (job_q == JOB_COIN) begin
            state_d = COOL;
            cnt_d   = COOL_LD;
          end else begin
            state_d = START;
            cnt_d   = PULSE_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = COOL;
          cnt_d   = COOL_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      COOL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new press of the running job re-queues it; a press on an already-queued job is absorbed
    pend_d = pend_d | edge_now;

    coin_d   = (state_d == COIN);
    start1_d = (state_d == START) && (job_d == JOB_START1);
    start2_d = (state_d == START) && (job_d == JOB_START2);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLK_IN or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= IDLE;
      job_q        <= JOB_START1;
      cnt_q        <= '0;
      coins_left_q <= 2'd0;
      in_q         <= 3'b000;
      pend_q       <= 3'b000;
      coin_q       <= 1'b0;
      start1_q     <= 1'b0;
      start2_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      cnt_q        <= cnt_d;
      coins_left_q <= coins_left_d;
      in_q         <= in_d;
      pend_q       <= pend_d;
      coin_q       <= coin_d;
      start1_q     <= start1_d;
      start2_q     <= start2_d;
      busy_q       <= busy_d;
    end
  end

  assign O_COIN   = coin_q;
  assign O_START1 = start1_q;
  assign O_START2 = start2_q;
  assign O_BUSY   = busy_q;

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Directed bench for coin_start_sequencer with PULSE=4, GAP=3, COOLDOWN=5.
// Cycle N: inputs driven and outputs sampled at the negedge inside cycle N; cycle 0 follows reset release.
module tb_coin_start_sequencer;

  logic clk = 1'b0;
  logic I_RESET, I_START1, I_START2, I_COIN;
  logic O_COIN, O_START1, O_START2, O_BUSY;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc;
  int coin_rises, s1_rises, s2_rises, onehot_viol;
  logic prev_coin, prev_s1, prev_s2;
  logic coin_log [0:255];
  logic s1_log   [0:255];
  logic s2_log   [0:255];
  logic busy_log [0:255];

  coin_start_sequencer #(
    .PULSE_CYC(4),
    .GAP_CYC(3),
    .COOLDOWN_CYC(5)
  ) dut (
    .CLK_IN(clk),
    .I_RESET(I_RESET),
    .I_START1(I_START1),
    .I_START2(I_START2),
    .I_COIN(I_COIN),
    .O_COIN(O_COIN),
    .O_START1(O_START1),
    .O_START2(O_START2),
    .O_BUSY(O_BUSY)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, log the outputs of that cycle, advance to the next negedge
  task automatic step(input logic s1, input logic s2, input logic c);
    I_START1 = s1;
    I_START2 = s2;
    I_COIN   = c;
    coin_log[cyc] = O_COIN;
    s1_log[cyc]   = O_START1;
    s2_log[cyc]   = O_START2;
    busy_log[cyc] = O_BUSY;
    if (O_COIN === 1'b1 && prev_coin !== 1'b1) coin_rises++;
    if (O_START1 === 1'b1 && prev_s1 !== 1'b1) s1_rises++;
    if (O_START2 === 1'b1 && prev_s2 !== 1'b1) s2_rises++;
    if (int'(O_COIN) + int'(O_START1) + int'(O_START2) > 1) onehot_viol++;
    prev_coin = O_COIN;
    prev_s1   = O_START1;
    prev_s2   = O_START2;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    I_RESET  = 1'b1;
    I_START1 = 1'b0;
    I_START2 = 1'b0;
    I_COIN   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    I_RESET = 1'b0;
    cyc = 0;
    coin_rises = 0; s1_rises = 0; s2_rises = 0; onehot_viol = 0;
    prev_coin = 1'b0; prev_s1 = 1'b0; prev_s2 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      coin_log[i] = 1'b0; s1_log[i] = 1'b0; s2_log[i] = 1'b0; busy_log[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    I_RESET = 1'b1; I_START1 = 1'b1; I_START2 = 1'b1; I_COIN = 1'b1;
    #2;
    total_cnt++;
    if ({O_COIN, O_START1, O_START2, O_BUSY} !== 4'b0000)
      $display("[TB] FAIL reset_async got=%b exp=0000", {O_COIN, O_START1, O_START2, O_BUSY});
    else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({O_COIN, O_START1, O_START2, O_BUSY} !== 4'b0000)
      $display("[TB] FAIL reset_held got=%b exp=0000", {O_COIN, O_START1, O_START2, O_BUSY});
    else pass_cnt++;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (coin_rises + s1_rises + s2_rises !== 0 || busy_log[11] !== 1'b0)
      $display("[TB] FAIL reset_quiet got=%0d pulses busy=%b exp=0 pulses busy=0",
               coin_rises + s1_rises + s2_rises, busy_log[11]);
    else pass_cnt++;
  endtask

  task automatic test_start1();
    do_reset();
    for (int i = 0; i < 40; i++) step(cyc >= 10 && cyc < 13, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      total_cnt++;
      if (coin_log[i] !== (i >= 12 && i <= 15))
        $display("[TB] FAIL s1_coin cyc=%0d got=%b exp=%b", i, coin_log[i], (i >= 12 && i <= 15));
      else pass_cnt++;
      total_cnt++;
      if (s1_log[i] !== (i >= 19 && i <= 22))
        $display("[TB] FAIL s1_start cyc=%0d got=%b exp=%b", i, s1_log[i], (i >= 19 && i <= 22));
      else pass_cnt++;
      total_cnt++;
      if (busy_log[i] !== (i >= 12 && i <= 27))
        $display("[TB] FAIL s1_busy cyc=%0d got=%b exp=%b", i, busy_log[i], (i >= 12 && i <= 27));
      else pass_cnt++;
    end
    total_cnt++;
    if (s2_rises !== 0) $display("[TB] FAIL s1_no_start2 got=%0d exp=0", s2_rises);
    else pass_cnt++;
  endtask

  task automatic test_start2();
    do_reset();
    for (int i = 0; i < 45; i++) step(1'b0, cyc >= 10 && cyc < 13, 1'b0);
    for (int i = 0; i < 42; i++) begin
      total_cnt++;
      if (coin_log[i] !== ((i >= 12 && i <= 15) || (i >= 19 && i <= 22)))
        $display("[TB] FAIL s2_coin cyc=%0d got=%b exp=%b", i, coin_log[i],
                 ((i >= 12 && i <= 15) || (i >= 19 && i <= 22)));
      else pass_cnt++;
      total_cnt++;
      if (s2_log[i] !== (i >= 26 && i <= 29))
        $display("[TB] FAIL s2_start cyc=%0d got=%b exp=%b", i, s2_log[i], (i >= 26 && i <= 29));
      else pass_cnt++;
      total_cnt++;
      if (busy_log[i] !== (i >= 12 && i <= 34))
        $display("[TB] FAIL s2_busy cyc=%0d got=%b exp=%b", i, busy_log[i], (i >= 12 && i <= 34));
      else pass_cnt++;
    end
    total_cnt++;
    if (s1_rises !== 0) $display("[TB] FAIL s2_no_start1 got=%0d exp=0", s1_rises);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 80; i++) step(cyc >= 10 && cyc < 12, cyc >= 10 && cyc < 12, cyc >= 10 && cyc < 12);
    total_cnt++;
    if (coin_rises !== 4) $display("[TB] FAIL b2b_coins got=%0d exp=4", coin_rises);
    else pass_cnt++;
    total_cnt++;
    if (s1_rises !== 1) $display("[TB] FAIL b2b_start1 got=%0d exp=1", s1_rises);
    else pass_cnt++;
    total_cnt++;
    if (s2_rises !== 1) $display("[TB] FAIL b2b_start2 got=%0d exp=1", s2_rises);
    else pass_cnt++;
    total_cnt++;
    if (onehot_viol !== 0) $display("[TB] FAIL b2b_onehot got=%0d exp=0", onehot_viol);
    else pass_cnt++;
    total_cnt++;
    if ({busy_log[27], busy_log[28], busy_log[29]} !== 3'b101)
      $display("[TB] FAIL b2b_gap1 got=%b exp=101", {busy_log[27], busy_log[28], busy_log[29]});
    else pass_cnt++;
    total_cnt++;
    if ({busy_log[51], busy_log[52], busy_log[53]} !== 3'b101)
      $display("[TB] FAIL b2b_gap2 got=%b exp=101", {busy_log[51], busy_log[52], busy_log[53]});
    else pass_cnt++;
    total_cnt++;
    if ({busy_log[64], busy_log[65], busy_log[79]} !== 3'b100)
      $display("[TB] FAIL b2b_end got=%b exp=100", {busy_log[64], busy_log[65], busy_log[79]});
    else pass_cnt++;
    total_cnt++;
    if ({s1_log[19], s2_log[43], s2_log[46], coin_log[53], coin_log[56]} !== 5'b11111)
      $display("[TB] FAIL b2b_order got=%b exp=11111",
               {s1_log[19], s2_log[43], s2_log[46], coin_log[53], coin_log[56]});
    else pass_cnt++;
    total_cnt++;
    if ({coin_log[36], coin_log[57], s2_log[47]} !== 3'b100)
      $display("[TB] FAIL b2b_edges got=%b exp=100", {coin_log[36], coin_log[57], s2_log[47]});
    else pass_cnt++;
  endtask

  task automatic test_repress();
    do_reset();
    for (int i = 0; i < 70; i++)
      step((cyc >= 10 && cyc < 12) || (cyc >= 14 && cyc < 16) || (cyc >= 20 && cyc < 22), 1'b0, 1'b0);
    total_cnt++;
    if (coin_rises !== 2) $display("[TB] FAIL rep_coins got=%0d exp=2", coin_rises);
    else pass_cnt++;
    total_cnt++;
    if (s1_rises !== 2) $display("[TB] FAIL rep_start1 got=%0d exp=2", s1_rises);
    else pass_cnt++;
    total_cnt++;
    if ({busy_log[28], busy_log[29], coin_log[29], busy_log[45], busy_log[69]} !== 5'b01100)
      $display("[TB] FAIL rep_timing got=%b exp=01100",
               {busy_log[28], busy_log[29], coin_log[29], busy_log[45], busy_log[69]});
    else pass_cnt++;
    for (int i = 35; i <= 40; i++) begin
      total_cnt++;
      if (s1_log[i] !== (i >= 36 && i <= 39))
        $display("[TB] FAIL rep_start_win cyc=%0d got=%b exp=%b", i, s1_log[i], (i >= 36 && i <= 39));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midjob();
    logic any_high;
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, cyc >= 10 && cyc < 13, 1'b0);
    total_cnt++;
    if ({O_COIN, O_BUSY} !== 2'b11)
      $display("[TB] FAIL mid_in_coin2 got=%b exp=11", {O_COIN, O_BUSY});
    else pass_cnt++;
    I_RESET = 1'b1;
    #1;
    total_cnt++;
    if ({O_COIN, O_START1, O_START2, O_BUSY} !== 4'b0000)
      $display("[TB] FAIL mid_abort got=%b exp=0000", {O_COIN, O_START1, O_START2, O_BUSY});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    I_RESET = 1'b0;
    any_high = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (O_COIN !== 1'b0 || O_START1 !== 1'b0 || O_START2 !== 1'b0 || O_BUSY !== 1'b0) any_high = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    total_cnt++;
    if (any_high !== 1'b0) $display("[TB] FAIL mid_no_resume got=%b exp=0", any_high);
    else pass_cnt++;
  endtask

  task automatic test_held();
    do_reset();
    for (int i = 0; i < 150; i++) step(cyc >= 10 && cyc < 110, 1'b0, 1'b0);
    total_cnt++;
    if (coin_rises !== 1) $display("[TB] FAIL held_coins got=%0d exp=1", coin_rises);
    else pass_cnt++;
    total_cnt++;
    if (s1_rises !== 1) $display("[TB] FAIL held_start1 got=%0d exp=1", s1_rises);
    else pass_cnt++;
    total_cnt++;
    if ({busy_log[27], busy_log[28], busy_log[149]} !== 3'b100)
      $display("[TB] FAIL held_busy got=%b exp=100", {busy_log[27], busy_log[28], busy_log[149]});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_start1();
    test_start2();
    test_back_to_back();
    test_repress();
    test_reset_midjob();
    test_held();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
